exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/smolproc_pkg.sv | 51 +++++
 rtl/exec_unit_if.sv | 40 ++++
 rtl/alu8.sv | 32 +++
 rtl/exec_unit.sv | 118 +++++++++++
 tb/tb_exec_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/smolproc_pkg.sv
// Shared types for the smolproc execution unit: opcodes, FSM states, captured-op payload
// and opcode-class helpers.
package smolproc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned MUL_W  = 2 * DATA_W;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,  OP_MOV = 4'd1,  OP_LDI = 4'd2,  OP_ADD = 4'd3,
    OP_SUB = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_NOT = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_CMP = 4'd11,
    OP_MUL = 4'd12, OP_R13 = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } exec_state_e;

  typedef struct packed {
    opcode_e             code;
    logic [ADDR_W-1:0]   rd;
    logic [DATA_W-1:0]   imm;
    logic                use_imm;
  } op_t;

  function automatic logic uses_a(opcode_e op);
    return (op == OP_MOV) || ((op >= OP_ADD) && (op <= OP_CMP)) || (op == OP_MUL);
  endfunction

  function automatic logic uses_b(opcode_e op);
    return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_CMP) || (op == OP_MUL);
  endfunction

  function automatic logic writes_rd(opcode_e op);
    return (op == OP_MOV) || (op == OP_LDI) || ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_MUL);
  endfunction

  function automatic logic has_flags(opcode_e op);
    return (op >= OP_MOV) && (op <= OP_MUL);
  endfunction

  function automatic logic sets_carry(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
           (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Operation handshake plus register-file read/write ports of the execution unit.
interface exec_unit_if
  import smolproc_pkg::*;
();
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [ADDR_W-1:0] op_rd;
  logic [ADDR_W-1:0] op_rs_a;
  logic [ADDR_W-1:0] op_rs_b;
  logic [DATA_W-1:0] op_imm;
  logic              op_use_imm;

  logic              rf_read_en_A;
  logic              rf_read_en_B;
  logic [ADDR_W-1:0] rf_addr_read_A;
  logic [ADDR_W-1:0] rf_addr_read_B;
  logic [DATA_W-1:0] rf_data_A;
  logic [DATA_W-1:0] rf_data_B;

  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_addr_write;
  logic [DATA_W-1:0] rf_data_in;

  // Upstream / register-file side
  modport master (
    output op_valid, op_code, op_rd, op_rs_a, op_rs_b, op_imm, op_use_imm,
    output rf_data_A, rf_data_B,
    input  op_ready, rf_read_en_A, rf_read_en_B, rf_addr_read_A, rf_addr_read_B,
    input  rf_write_en, rf_addr_write, rf_data_in
  );

  // Execution-unit side
  modport slave (
    input  op_valid, op_code, op_rd, op_rs_a, op_rs_b, op_imm, op_use_imm,
    input  rf_data_A, rf_data_B,
    output op_ready, rf_read_en_A, rf_read_en_B, rf_addr_read_A, rf_addr_read_B,
    output rf_write_en, rf_addr_write, rf_data_in
  );
endinterface

// File: rtl/alu8.sv
// Single-cycle 8-bit ALU; MUL is sequenced by the caller and yields zero here.
module alu8
  import smolproc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum    = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    result = '0;
    carry  = 1'b0;
    unique case (opcode)
      OP_MOV: result = a;
      OP_LDI: result = b;
      OP_ADD: begin result = sum[DATA_W-1:0]; carry = sum[DATA_W]; end
      OP_SUB,
      OP_CMP: begin result = a - b; carry = (a < b); end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
      OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0]; end
      default: ;
    endcase
  end
endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: IDLE accepts and reads operands, EXEC computes (8 cycles
// of shift-add for MUL), WB drives the registered write port for one cycle.
module exec_unit
  import smolproc_pkg::*;
(
  input  logic       clk,
  input  logic       sync_rst,
  exec_unit_if.slave bus,
  output logic       flag_z,
  output logic       flag_c,
  output logic       busy
);
  exec_state_e       state_q, state_d;
  op_t               op_q;
  opcode_e           in_code;
  logic [CNT_W-1:0]  cnt_q;
  logic [MUL_W-1:0]  acc_q, acc_sum, partial;
  logic [DATA_W-1:0] a_q, b_q, a_op, b_op, b_src, alu_res, res;
  logic              alu_carry, carry, first;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign in_code = opcode_e'(bus.op_code);

  always_ff @(posedge clk) begin
    if (sync_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.op_valid) state_d = ST_EXEC;
      ST_EXEC: if ((op_q.code != OP_MUL) || (cnt_q == CNT_W'(7))) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready       = (state_q == ST_IDLE);
    busy               = (state_q != ST_IDLE);
    bus.rf_read_en_A   = 1'b0;
    bus.rf_read_en_B   = 1'b0;
    bus.rf_addr_read_A = bus.op_rs_a;
    bus.rf_addr_read_B = bus.op_rs_b;
    if ((state_q == ST_IDLE) && bus.op_valid && !sync_rst) begin
      bus.rf_read_en_A = uses_a(in_code);
      bus.rf_read_en_B = uses_b(in_code) && !bus.op_use_imm;
    end
  end

  assign bus.rf_write_en   = wr_en_q;
  assign bus.rf_addr_write = wr_addr_q;
  assign bus.rf_data_in    = wr_data_q;

  // Register-file data is only valid in the first EXEC cycle; MUL keeps a copy after that.
  assign first   = (cnt_q == '0);
  assign b_src   = (op_q.use_imm || (op_q.code == OP_LDI)) ? op_q.imm : bus.rf_data_B;
  assign a_op    = first ? bus.rf_data_A : a_q;
  assign b_op    = first ? b_src : b_q;
  assign partial = b_op[cnt_q] ? (MUL_W'(a_op) << cnt_q) : '0;
  assign acc_sum = acc_q + partial;

  alu8 u_alu (
    .a      (a_op),
    .b      (b_op),
    .opcode (op_q.code),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign res   = (op_q.code == OP_MUL) ? acc_sum[DATA_W-1:0] : alu_res;
  assign carry = (op_q.code == OP_MUL) ? (acc_sum[MUL_W-1:DATA_W] != '0) : alu_carry;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      op_q      <= '{code: OP_NOP, rd: '0, imm: '0, use_imm: 1'b0};
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      if ((state_q == ST_IDLE) && bus.op_valid) begin
        op_q  <= '{code: in_code, rd: bus.op_rd, imm: bus.op_imm, use_imm: bus.op_use_imm};
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (state_q == ST_EXEC) begin
        if (op_q.code == OP_MUL) begin
          a_q   <= a_op;
          b_q   <= b_op;
          acc_q <= acc_sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        // Results and flags land on the EXEC-to-WB edge.
        if (state_d == ST_WB) begin
          if (writes_rd(op_q.code)) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= op_q.rd;
            wr_data_q <= res;
          end
          if (has_flags(op_q.code))  flag_z <= (res == '0);
          if (sets_carry(op_q.code)) flag_c <= carry;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: vector table plus scoreboard of expected register-file writes,
// with a behavioural register file and a hand-written mid-MUL reset sequence.
module tb_exec_unit;
  import smolproc_pkg::*;

  logic clk = 1'b0;
  logic sync_rst;
  logic flag_z, flag_c, busy;

  exec_unit_if bus ();

  exec_unit dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .bus      (bus),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [1:0] rd, ra, rb;
    logic [7:0] imm;
    logic       ui, wr;
    logic [7:0] data;
    logic       z, c, ena, enb;
  } vec_t;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t  sb[$];
  vec_t vecs[19];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [7:0] regs [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with one-cycle read latency
  always @(posedge clk) begin
    if (sync_rst) begin
      regs[0] <= 8'd0; regs[1] <= 8'd5; regs[2] <= 8'd0; regs[3] <= 8'd5;
      bus.rf_data_A <= 8'd0;
      bus.rf_data_B <= 8'd0;
    end else begin
      if (bus.rf_write_en) regs[bus.rf_addr_write] <= bus.rf_data_in;
      if (bus.rf_read_en_A) bus.rf_data_A <= regs[bus.rf_addr_read_A];
      if (bus.rf_read_en_B) bus.rf_data_B <= regs[bus.rf_addr_read_B];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer and read-enable watchdog
  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_write_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.rf_addr_write), 32'(e.addr));
        check("wr_data", 32'(bus.rf_data_in), 32'(e.data));
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if ((bus.rf_read_en_A === 1'b1) || (bus.rf_read_en_B === 1'b1))
      check("stray_read_en", 32'(sync_rst || !(bus.op_valid && bus.op_ready)), 32'd0);
  end

  function automatic vec_t mk(input logic [3:0] code, input logic [1:0] rd, ra, rb,
                              input logic [7:0] imm, input logic ui, wr,
                              input logic [7:0] data, input logic z, c, ena, enb);
    vec_t v;
    v.code = code; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm; v.ui = ui;
    v.wr = wr; v.data = data; v.z = z; v.c = c; v.ena = ena; v.enb = enb;
    return v;
  endfunction

  task automatic run_op(input int idx, input vec_t v);
    int lat, t_acc, n;
    wr_t e;
    lat = (v.code == 4'd12) ? 10 : 3;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = v.code; bus.op_rd = v.rd;
    bus.op_rs_a = v.ra; bus.op_rs_b = v.rb; bus.op_imm = v.imm; bus.op_use_imm = v.ui;
    @(negedge clk);
    check($sformatf("v%0d_issue_ready", idx), 32'(bus.op_ready), 32'd1);
    check($sformatf("v%0d_rd_en_A", idx), 32'(bus.rf_read_en_A), 32'(v.ena));
    check($sformatf("v%0d_rd_en_B", idx), 32'(bus.rf_read_en_B), 32'(v.enb));
    if (v.ena) check($sformatf("v%0d_rd_addr_A", idx), 32'(bus.rf_addr_read_A), 32'(v.ra));
    if (v.enb) check($sformatf("v%0d_rd_addr_B", idx), 32'(bus.rf_addr_read_B), 32'(v.rb));
    t_acc = cyc;
    if (v.wr) begin
      e.addr = v.rd; e.data = v.data; e.cyc = t_acc + lat - 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    // Garbage on op_* while busy must be ignored
    bus.op_code = 4'd3; bus.op_rd = ~v.rd;
    n = 1;
    while ((bus.op_ready !== 1'b1) && (n < 20)) begin
      if (n == lat - 1) bus.op_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.op_valid = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(n), 32'(lat));
    check($sformatf("v%0d_flag_z", idx), 32'(flag_z), 32'(v.z));
    check($sformatf("v%0d_flag_c", idx), 32'(flag_c), 32'(v.c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              code   rd    ra    rb    imm    ui   wr   data   z    c    ena  enb
    vecs[0]  = mk(4'd11, 2'd0, 2'd1, 2'd3, 8'h00, 0, 0, 8'h00, 1, 0, 1, 1); // CMP r1,r3
    vecs[1]  = mk(4'd4,  2'd2, 2'd0, 2'd1, 8'h00, 0, 1, 8'hFB, 0, 1, 1, 1); // SUB 0-5
    vecs[2]  = mk(4'd3,  2'd0, 2'd1, 2'd3, 8'h00, 0, 1, 8'h0A, 0, 0, 1, 1); // ADD 5+5
    vecs[3]  = mk(4'd12, 2'd0, 2'd1, 2'd3, 8'h00, 0, 1, 8'h19, 0, 0, 1, 1); // MUL 5*5
    vecs[4]  = mk(4'd2,  2'd2, 2'd0, 2'd0, 8'hFF, 0, 1, 8'hFF, 0, 0, 0, 0); // LDI r2=FF
    vecs[5]  = mk(4'd3,  2'd2, 2'd2, 2'd0, 8'h01, 1, 1, 8'h00, 1, 1, 1, 0); // ADD FF+1
    vecs[6]  = mk(4'd5,  2'd3, 2'd1, 2'd0, 8'h0C, 1, 1, 8'h04, 0, 1, 1, 0); // AND 5&C
    vecs[7]  = mk(4'd6,  2'd3, 2'd3, 2'd1, 8'h00, 0, 1, 8'h05, 0, 1, 1, 1); // OR 4|5
    vecs[8]  = mk(4'd7,  2'd3, 2'd3, 2'd1, 8'h00, 0, 1, 8'h00, 1, 1, 1, 1); // XOR 5^5
    vecs[9]  = mk(4'd8,  2'd3, 2'd1, 2'd0, 8'h00, 0, 1, 8'hFA, 0, 1, 1, 0); // NOT 5
    vecs[10] = mk(4'd9,  2'd3, 2'd3, 2'd0, 8'h00, 0, 1, 8'hF4, 0, 1, 1, 0); // SHL FA
    vecs[11] = mk(4'd10, 2'd3, 2'd1, 2'd0, 8'h00, 0, 1, 8'h02, 0, 1, 1, 0); // SHR 5
    vecs[12] = mk(4'd10, 2'd3, 2'd3, 2'd0, 8'h00, 0, 1, 8'h01, 0, 0, 1, 0); // SHR 2
    vecs[13] = mk(4'd0,  2'd1, 2'd1, 2'd2, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0); // NOP
    vecs[14] = mk(4'd14, 2'd1, 2'd1, 2'd2, 8'h33, 0, 0, 8'h00, 0, 0, 0, 0); // illegal
    vecs[15] = mk(4'd1,  2'd0, 2'd3, 2'd0, 8'h00, 0, 1, 8'h01, 0, 0, 1, 0); // MOV r0=r3
    vecs[16] = mk(4'd2,  2'd1, 2'd0, 2'd0, 8'h20, 0, 1, 8'h20, 0, 0, 0, 0); // LDI r1=20
    vecs[17] = mk(4'd2,  2'd2, 2'd0, 2'd0, 8'h10, 0, 1, 8'h10, 0, 0, 0, 0); // LDI r2=10
    vecs[18] = mk(4'd12, 2'd3, 2'd1, 2'd2, 8'h00, 0, 1, 8'h00, 1, 1, 1, 1); // MUL 20*10

    // Reset with a valid ADD pending: nothing may be read or captured
    sync_rst = 1'b1;
    bus.op_valid = 1'b1; bus.op_code = 4'd3; bus.op_rd = 2'd0;
    bus.op_rs_a = 2'd1; bus.op_rs_b = 2'd3; bus.op_imm = 8'h00; bus.op_use_imm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en_A", 32'(bus.rf_read_en_A), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    check("rst_flag_c", 32'(flag_c), 32'd0);
    check("rst_write_en", 32'(bus.rf_write_en), 32'd0);
    check("rst_addr_write", 32'(bus.rf_addr_write), 32'd0);
    check("rst_data_in", 32'(bus.rf_data_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    sync_rst = 1'b0;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.op_ready), 32'd1);

    for (int i = 0; i < 19; i++) run_op(i, vecs[i]);

    // MUL interrupted by reset in its 4th EXEC cycle
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = 4'd12; bus.op_rd = 2'd0;
    bus.op_rs_a = 2'd1; bus.op_rs_b = 2'd3; bus.op_use_imm = 1'b0;
    @(negedge clk);
    check("mulrst_issue_ready", 32'(bus.op_ready), 32'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sync_rst = 1'b1;
    @(negedge clk);
    check("mulrst_busy_exec4", 32'(busy), 32'd1);
    @(posedge clk); #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("mulrst_ready", 32'(bus.op_ready), 32'd1);
    check("mulrst_flag_z", 32'(flag_z), 32'd0);
    check("mulrst_flag_c", 32'(flag_c), 32'd0);
    check("mulrst_write_en", 32'(bus.rf_write_en), 32'd0);
    repeat (12) @(posedge clk);
    run_op(100, vecs[2]);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
